// File: rtl/led_bar_driver.sv
// led_bar_driver
//   Output stage after the LED bar data mux. It takes the mux's active-low
//   8-bit pattern and drives the physical LED bar pins. On top of that it
//   adds per-bit activity stretching, global PWM brightness, freeze and
//   lamp test. The output is active-low (0 = LED lit).
//
//   Optional feature macro: LED_STRETCH_EN
//     defined   : per-bit stretch counters hold a lit bit for STRETCH_CYCLES
//     undefined : no counters; the stretched pattern equals the sampled one
//
//   Ports
//     clock       in   system clock, all state on the rising edge
//     reset_n     in   asynchronous active-low reset
//     ledIn       in   [7:0] active-low LED pattern from the mux
//     brightness  in   [PWM_BITS-1:0] duty select (0 = off, all-ones = full)
//     lampTest    in   force every LED lit at full brightness
//     freeze      in   hold the currently displayed pattern
//     ledOut      out  [7:0] active-low LED pins
//
//   Pipeline: sample (r_lit) -> hold (r_hold) -> output (r_led_out), which
//   gives 3 clocks from ledIn to ledOut at full duty.
module led_bar_driver #(
    parameter int STRETCH_CYCLES = 2000000,
    parameter int PRESCALE       = 256,
    parameter int PWM_BITS       = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [7:0]          ledIn,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                lampTest,
    input  logic                freeze,
    output logic [7:0]          ledOut
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [7:0]          r_lit;
    logic [7:0]          r_hold;
    logic [7:0]          r_led_out;
    logic [7:0]          w_stretched;
    logic [PS_W-1:0]     r_prescale;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                w_tick;
    logic                w_pwm_on;

    // Stage 1: convert to active-high and register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lit <= '0;
        end else begin
            r_lit <= ~ledIn;
        end
    end

`ifdef LED_STRETCH_EN
    localparam int               CNT_W    = $clog2(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [8];

    // Down-counters: a lit bit reloads (no accumulation), otherwise count to 0.
    // A one-cycle lit pulse yields 1 + (STRETCH_CYCLES-1) cycles of stretched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_lit[i]) begin
                    r_cnt[i] <= CNT_LOAD;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_stretched = r_lit;
        for (int i = 0; i < 8; i++) begin
            if (r_cnt[i] != '0) begin
                w_stretched[i] = 1'b1;
            end
        end
    end
`else
    assign w_stretched = r_lit;
`endif

    // Hold register; the stretch counters keep running while frozen
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (!freeze) begin
            r_hold <= w_stretched;
        end
    end

    // PWM timebase
    assign w_tick = (r_prescale == PS_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_pwm_cnt  <= '0;
            r_duty     <= '0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
                // Only latch a new duty at the period boundary so a change
                // mid-period cannot produce a truncated or doubled pulse.
                if (r_pwm_cnt == '1) begin
                    r_duty <= brightness;
                end
            end
        end
    end

    assign w_pwm_on = (r_duty == '1) || (r_pwm_cnt < r_duty);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_led_out <= 8'hFF;
        end else if (lampTest) begin
            r_led_out <= 8'h00;
        end else begin
            r_led_out <= ~(r_hold & {8{w_pwm_on}});
        end
    end

    assign ledOut = r_led_out;

endmodule

// File: tb/tb_led_bar_driver.sv
// Testbench for led_bar_driver with STRETCH_CYCLES=8, PRESCALE=2, PWM_BITS=4.
// The reference model tracks, per bit, the last clock edge at which the bit
// was sampled lit, and derives the PWM phase from the number of edges since
// reset. Directed test-plan scenarios run first, then a randomized run.
module tb_led_bar_driver;

    localparam int STRETCH = 8;
    localparam int PRESC   = 2;
    localparam int PERIOD  = PRESC * 16;
`ifdef LED_STRETCH_EN
    localparam int S_EFF = STRETCH;
`else
    localparam int S_EFF = 1;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] ledIn;
    logic [3:0] brightness;
    logic       lampTest;
    logic       freeze;
    logic [7:0] ledOut;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_n;
    int         m_last [8];
    logic [7:0] m_hold;
    logic [3:0] m_duty;
    logic [7:0] m_exp;

    int cnt_all_lit;
    int cnt_bit0_lit;

    led_bar_driver #(
        .STRETCH_CYCLES (STRETCH),
        .PRESCALE       (PRESC),
        .PWM_BITS       (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ledIn      (ledIn),
        .brightness (brightness),
        .lampTest   (lampTest),
        .freeze     (freeze),
        .ledOut     (ledOut)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_hold = '0;
        m_duty = '0;
        m_exp  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            m_last[i] = -1000;
        end
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    // m_n counts edges already taken since reset.
    task automatic model_step();
        logic       pwm_on;
        logic [7:0] stretched;
        pwm_on = (m_duty == 4'hF) || (((m_n / PRESC) % 16) < int'(m_duty));
        stretched = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_n - m_last[i] < S_EFF) stretched[i] = 1'b1;
        end
        m_exp = lampTest ? 8'h00 : ~(m_hold & {8{pwm_on}});
        if (!freeze) m_hold = stretched;
        if ((m_n % PERIOD) == PERIOD - 1) m_duty = brightness;
        for (int i = 0; i < 8; i++) begin
            if (!ledIn[i]) m_last[i] = m_n + 1;
        end
        m_n++;
    endtask

    // Run n clocks, checking ledOut against the model after each edge.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            chk("ledOut", ledOut, m_exp);
            if (ledOut == 8'h00) cnt_all_lit++;
            if (!ledOut[0]) cnt_bit0_lit++;
        end
    endtask

    // Asynchronous reset asserted between edges, released on a falling edge.
    task automatic do_reset(input int hold_cycles);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", ledOut, 8'hFF);
        model_reset();
        repeat (hold_cycles) @(negedge clock);
        chk("rst_hold", ledOut, 8'hFF);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b1;
        ledIn      = 8'h00;
        brightness = 4'd15;
        lampTest   = 1'b0;
        freeze     = 1'b0;
        model_reset();

        // Reset and first PWM boundary
        do_reset(3);
        cyc(40);
        chk("post_rst_lit", ledOut, 8'h00);

        // Single-cycle pulse on bit 0
        ledIn = 8'hFF;
        cyc(12);
        cnt_bit0_lit = 0;
        cnt_all_lit  = 0;
        ledIn = 8'hFE;
        cyc(1);
        ledIn = 8'hFF;
        cyc(20);
        chk("stretch_len", cnt_bit0_lit, S_EFF);
        chk("stretch_other", ledOut, 8'hFF);

        // Brightness 4 then 12
        ledIn = 8'h00;
        brightness = 4'd4;
        cyc(64);
        cnt_all_lit = 0;
        cyc(PERIOD);
        chk("duty4", cnt_all_lit, 8);
        brightness = 4'd12;
        cyc(10);
        cyc(54);
        cnt_all_lit = 0;
        cyc(PERIOD);
        chk("duty12", cnt_all_lit, 24);

        // Brightness zero
        brightness = 4'd0;
        cyc(40);
        cnt_all_lit = 0;
        cnt_bit0_lit = 0;
        cyc(2 * PERIOD);
        chk("duty0", cnt_bit0_lit, 0);
        chk("duty0_out", ledOut, 8'hFF);

        // Freeze
        brightness = 4'd15;
        ledIn = 8'h5A;
        cyc(40);
        freeze = 1'b1;
        ledIn = 8'hA5;
        cyc(20);
        chk("freeze_hold", ledOut, 8'h5A);
        freeze = 1'b0;
        cyc(20);
        chk("freeze_rel", ledOut, 8'hA5);

        // Lamp test overrides duty 0 and freeze
        brightness = 4'd0;
        cyc(70);
        chk("lamp_pre", ledOut, 8'hFF);
        freeze = 1'b1;
        lampTest = 1'b1;
        cyc(1);
        chk("lamp_on", ledOut, 8'h00);
        lampTest = 1'b0;
        cyc(1);
        chk("lamp_off", ledOut, 8'hFF);
        freeze = 1'b0;

        // Randomized run with a mid-stream reset
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 2) == 0)
                ledIn = 8'($urandom);
            else if ($urandom_range(0, 3) == 0)
                ledIn = ~(8'h01 << $urandom_range(0, 7));
            else
                ledIn = 8'hFF;
            if ($urandom_range(0, 40) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 15) == 0) freeze = ~freeze;
            lampTest = ($urandom_range(0, 30) == 0);
            if (k == 1000) begin
                ledIn = 8'h00;
                cyc(3);
                do_reset(2);
            end
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
